ring_decoder: RTL and testbench

- Receive-side companion to the one-hot ring counter.
- Samples an N-bit ring-counter bus and checks that it is one-hot and advances exactly one position per enabled clock (bit k takes bit k-1; bit 0 takes bit N-1).
- Reports the binary position, lock status, error pulses and a revolution count.
- Used wherever a ring-counter phase bus crosses into logic that needs an encoded index or a health monitor.

---
 rtl/ring_decoder.sv | 132 +++++++++++++
 tb/tb_ring_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// Receive-side monitor for a one-hot ring-counter bus: encodes the phase position,
// tracks lock on the rotation sequence, flags bad steps and counts full revolutions.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_HUNT   | no trusted history; waiting for any one-hot sample
// S_ACQ    | one-hot seen; counting consecutive good steps toward lock
// S_LOCKED | rotation confirmed; step and one-hot violations are reported
module ring_decoder #(
  parameter int N          = 6,
  parameter int LOCK_COUNT = 2,
  parameter int REV_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [N-1:0]         i,
  input  logic                 clr,
  output logic [$clog2(N)-1:0] index,
  output logic                 valid,
  output logic                 locked,
  output logic                 step_err,
  output logic                 onehot_err,
  output logic                 wrap,
  output logic [REV_W-1:0]     revs
);

  localparam int IDX_W = $clog2(N);
  localparam int CW    = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {S_HUNT, S_ACQ, S_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      p_q;
  logic [N-1:0]      rot;
  logic              oh;
  logic              step_ok;
  logic [IDX_W-1:0]  idx_enc;
  logic [REV_W-1:0]  revs_d;
  logic              step_err_d;
  logic              onehot_err_d;
  logic              wrap_d;

  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign oh      = (i != '0) && ((i & (i - N'(1))) == '0);
  assign rot     = {p_q[N-2:0], p_q[N-1]};
  assign step_ok = oh && (i == rot);
  assign locked  = (state_q == S_LOCKED);

  always_comb begin
    idx_enc = '0;
    for (int k = 0; k < N; k++) begin
      if (i[k]) idx_enc = IDX_W'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    revs_d       = revs;
    step_err_d   = 1'b0;
    onehot_err_d = 1'b0;
    wrap_d       = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (oh) begin
          state_d = S_ACQ;
          cnt_d   = '0;
        end
      end
      S_ACQ: begin
        if (step_ok) begin
          if (cnt_q + CW'(1) == CW'(LOCK_COUNT)) state_d = S_LOCKED;
          else                                   cnt_d   = cnt_q + CW'(1);
        end else if (oh) begin
          cnt_d = '0;
        end else begin
          state_d      = S_HUNT;
          onehot_err_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if (step_ok) begin
          if (i[0]) begin
            wrap_d = 1'b1;
            revs_d = revs + REV_W'(1);
          end
        end else if (oh) begin
          state_d    = S_ACQ;
          cnt_d      = '0;
          step_err_d = 1'b1;
        end else begin
          state_d      = S_HUNT;
          onehot_err_d = 1'b1;
        end
      end
      default: state_d = S_HUNT;
    endcase
    // Clear wins over a same-edge increment; the wrap pulse is still reported.
    if (clr) revs_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      cnt_q      <= '0;
      p_q        <= '0;
      index      <= '0;
      valid      <= 1'b0;
      revs       <= '0;
      step_err   <= 1'b0;
      onehot_err <= 1'b0;
      wrap       <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= i;
      index      <= oh ? idx_enc : '0;
      valid      <= oh;
      revs       <= revs_d;
      step_err   <= step_err_d;
      onehot_err <= onehot_err_d;
      wrap       <= wrap_d;
    end else begin
      step_err   <= 1'b0;
      onehot_err <= 1'b0;
      wrap       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder: two instances share stimulus, one with an
// 8-bit revolution counter and one with a 2-bit counter to exercise rollover.
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [5:0] i;
  logic       clr;

  logic [2:0] index_a, index_b;
  logic       valid_a, locked_a, step_err_a, onehot_err_a, wrap_a;
  logic       valid_b, locked_b, step_err_b, onehot_err_b, wrap_b;
  logic [7:0] revs_a;
  logic [1:0] revs_b;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_a  = 0;
  int exp_b  = 0;

  always #5 clk = ~clk;

  ring_decoder #(.N(6), .LOCK_COUNT(2), .REV_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .i(i), .clr(clr),
    .index(index_a), .valid(valid_a), .locked(locked_a),
    .step_err(step_err_a), .onehot_err(onehot_err_a), .wrap(wrap_a),
    .revs(revs_a)
  );

  ring_decoder #(.N(6), .LOCK_COUNT(2), .REV_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .i(i), .clr(clr),
    .index(index_b), .valid(valid_b), .locked(locked_b),
    .step_err(step_err_b), .onehot_err(onehot_err_b), .wrap(wrap_b),
    .revs(revs_b)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic tick(input logic [5:0] v, input logic ce_v, input logic clr_v);
    i   = v;
    ce  = ce_v;
    clr = clr_v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input string tag, input int se, input int oe, input int w);
    check({tag, ".step_err"},   int'(step_err_a),   se);
    check({tag, ".onehot_err"}, int'(onehot_err_a), oe);
    check({tag, ".wrap"},       int'(wrap_a),       w);
  endtask

  // One full revolution from index 0 back to index 0 while locked.
  task automatic revolution(input logic clr_last);
    logic [5:0] v;
    v = 6'b000001;
    for (int s = 1; s < 6; s++) begin
      v = {v[4:0], v[5]};
      tick(v, 1'b1, 1'b0);
      check("rev.index", int'(index_a), s);
      check("rev.wrap_idle", int'(wrap_a), 0);
    end
    tick(6'b000001, 1'b1, clr_last);
    exp_a = clr_last ? 0 : (exp_a + 1) % 256;
    exp_b = clr_last ? 0 : (exp_b + 1) % 4;
    pulses("rev.end", 0, 0, 1);
    check("rev.wrap_b", int'(wrap_b), 1);
    check("rev.locked", int'(locked_a), 1);
    check("rev.revs_a", int'(revs_a), exp_a);
    check("rev.revs_b", int'(revs_b), exp_b);
  endtask

  initial begin
    logic [5:0] seq [7];
    seq = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
            6'b010000, 6'b100000, 6'b000001};
    rst_n = 1'b0;
    ce    = 1'b0;
    i     = '0;
    clr   = 1'b0;

    #12;
    check("rst.index",  int'(index_a),  0);
    check("rst.valid",  int'(valid_a),  0);
    check("rst.locked", int'(locked_a), 0);
    pulses("rst", 0, 0, 0);
    check("rst.revs",   int'(revs_a),   0);
    #5 rst_n = 1'b1;

    // lock and wrap
    for (int s = 0; s < 7; s++) begin
      tick(seq[s], 1'b1, 1'b0);
      check("lw.index", int'(index_a), s % 6);
      check("lw.valid", int'(valid_a), 1);
      check("lw.locked", int'(locked_a), (s >= 2) ? 1 : 0);
      pulses("lw", 0, 0, (s == 6) ? 1 : 0);
    end
    exp_a = 1;
    exp_b = 1;
    check("lw.revs_a", int'(revs_a), 1);
    check("lw.revs_b", int'(revs_b), 1);

    // skipped step then relock
    tick(6'b000100, 1'b1, 1'b0);
    pulses("skip", 1, 0, 0);
    check("skip.locked", int'(locked_a), 0);
    check("skip.valid",  int'(valid_a),  1);
    check("skip.index",  int'(index_a),  2);
    tick(6'b001000, 1'b1, 1'b0);
    pulses("skip1", 0, 0, 0);
    check("skip1.locked", int'(locked_a), 0);
    tick(6'b010000, 1'b1, 1'b0);
    check("skip2.locked", int'(locked_a), 1);
    check("skip2.revs",   int'(revs_a),   1);

    // non-one-hot while locked, then silent in hunt
    tick(6'b000011, 1'b1, 1'b0);
    pulses("nonoh", 0, 1, 0);
    check("nonoh.valid",  int'(valid_a),  0);
    check("nonoh.index",  int'(index_a),  0);
    check("nonoh.locked", int'(locked_a), 0);
    tick(6'b000000, 1'b1, 1'b0);
    pulses("hunt0", 0, 0, 0);
    check("hunt0.valid", int'(valid_a), 0);

    // reacquire up to index 3
    tick(6'b000001, 1'b1, 1'b0);
    check("acq0.locked", int'(locked_a), 0);
    tick(6'b000010, 1'b1, 1'b0);
    check("acq1.locked", int'(locked_a), 0);
    tick(6'b000100, 1'b1, 1'b0);
    check("acq2.locked", int'(locked_a), 1);
    tick(6'b001000, 1'b1, 1'b0);
    check("acq3.index", int'(index_a), 3);

    // CE gating
    for (int s = 0; s < 4; s++) begin
      tick(6'b101010, 1'b0, 1'b0);
      check("ce0.index",  int'(index_a),  3);
      check("ce0.locked", int'(locked_a), 1);
      check("ce0.valid",  int'(valid_a),  1);
      pulses("ce0", 0, 0, 0);
    end
    tick(6'b010000, 1'b1, 1'b0);
    check("ce1.index",  int'(index_a),  4);
    check("ce1.locked", int'(locked_a), 1);
    pulses("ce1", 0, 0, 0);
    tick(6'b100000, 1'b1, 1'b0);
    tick(6'b000001, 1'b1, 1'b0);
    exp_a = 2;
    exp_b = 2;
    check("ce2.wrap",   int'(wrap_a), 1);
    check("ce2.revs_a", int'(revs_a), 2);
    check("ce2.revs_b", int'(revs_b), 2);

    // rollover of the narrow counter, then clear on a wrap edge
    for (int r = 0; r < 3; r++) revolution(1'b0);
    revolution(1'b1);
    for (int r = 0; r < 5; r++) revolution(1'b0);
    check("pre.revs_a", int'(revs_a), 5);

    // async reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("arst.locked", int'(locked_a), 0);
    check("arst.valid",  int'(valid_a),  0);
    check("arst.revs_a", int'(revs_a),   0);
    check("arst.revs_b", int'(revs_b),   0);
    #2 rst_n = 1'b1;
    tick(6'b000001, 1'b1, 1'b0);
    check("post0.locked", int'(locked_a), 0);
    check("post0.valid",  int'(valid_a),  1);
    pulses("post0", 0, 0, 0);
    tick(6'b000010, 1'b1, 1'b0);
    check("post1.locked", int'(locked_a), 0);
    tick(6'b000100, 1'b1, 1'b0);
    check("post2.locked", int'(locked_a), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
